// File: rtl/mem_port_arbiter.sv
// Two-port (IFU/LSU) arbiter onto a single memory bus: one transaction in flight,
// alternating priority on contention, and a timeout that turns a lost response into an error.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ifu_pend_q, ifu_pend_d;
  logic [31:0] ifu_addr_q, ifu_addr_d;
  logic        lsu_pend_q, lsu_pend_d;
  logic [31:0] lsu_addr_q, lsu_addr_d;
  logic [1:0]  lsu_size_q, lsu_size_d;
  logic        lsu_wen_q, lsu_wen_d;
  logic [31:0] lsu_wdata_q, lsu_wdata_d;
  logic [3:0]  lsu_wmask_q, lsu_wmask_d;
  // last_lsu_q doubles as the owner of the transaction in flight; 0 after reset so LSU wins first
  logic        last_lsu_q, last_lsu_d;
  logic [15:0] cnt_q, cnt_d;

  logic        mem_reqValid_q, mem_reqValid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        ifu_respValid_q, ifu_respValid_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic        ifu_err_q, ifu_err_d;
  logic        lsu_respValid_q, lsu_respValid_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        lsu_err_q, lsu_err_d;

  logic        pick_lsu;
  logic        resp_fire;
  logic [31:0] resp_data;

  always_comb begin
    state_d         = state_q;
    ifu_pend_d      = ifu_pend_q;
    ifu_addr_d      = ifu_addr_q;
    lsu_pend_d      = lsu_pend_q;
    lsu_addr_d      = lsu_addr_q;
    lsu_size_d      = lsu_size_q;
    lsu_wen_d       = lsu_wen_q;
    lsu_wdata_d     = lsu_wdata_q;
    lsu_wmask_d     = lsu_wmask_q;
    last_lsu_d      = last_lsu_q;
    cnt_d           = cnt_q;
    mem_reqValid_d  = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_size_d      = mem_size_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    ifu_respValid_d = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    ifu_err_d       = 1'b0;
    lsu_respValid_d = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;
    lsu_err_d       = 1'b0;
    pick_lsu        = lsu_pend_q && (!ifu_pend_q || !last_lsu_q);
    resp_fire       = mem_respValid || (cnt_q == TO_LAST);
    resp_data       = mem_respValid ? mem_rdata : ERR_DATA;

    if (ifu_reqValid && !ifu_pend_q) begin
      ifu_pend_d = 1'b1;
      ifu_addr_d = ifu_addr;
    end
    if (lsu_reqValid && !lsu_pend_q) begin
      lsu_pend_d  = 1'b1;
      lsu_addr_d  = lsu_addr;
      lsu_size_d  = lsu_size;
      lsu_wen_d   = lsu_wen;
      lsu_wdata_d = lsu_wdata;
      lsu_wmask_d = lsu_wmask;
    end

    case (state_q)
      S_IDLE: begin
        if (ifu_pend_q || lsu_pend_q) begin
          state_d        = S_REQ;
          last_lsu_d     = pick_lsu;
          mem_reqValid_d = 1'b1;
          if (pick_lsu) begin
            mem_addr_d  = lsu_addr_q;
            mem_size_d  = lsu_size_q;
            mem_wen_d   = lsu_wen_q;
            mem_wdata_d = lsu_wdata_q;
            mem_wmask_d = lsu_wmask_q;
          end else begin
            // fetches are always full-word reads
            mem_addr_d  = ifu_addr_q;
            mem_size_d  = 2'd2;
            mem_wen_d   = 1'b0;
            mem_wdata_d = 32'h0;
            mem_wmask_d = 4'h0;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
      S_WAIT: begin
        if (resp_fire) begin
          state_d = S_RESP;
          if (last_lsu_q) begin
            lsu_respValid_d = 1'b1;
            lsu_rdata_d     = resp_data;
            lsu_err_d       = !mem_respValid;
          end else begin
            ifu_respValid_d = 1'b1;
            ifu_rdata_d     = resp_data;
            ifu_err_d       = !mem_respValid;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (last_lsu_q) lsu_pend_d = 1'b0;
        else            ifu_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      ifu_pend_q      <= 1'b0;
      ifu_addr_q      <= 32'h0;
      lsu_pend_q      <= 1'b0;
      lsu_addr_q      <= 32'h0;
      lsu_size_q      <= 2'd0;
      lsu_wen_q       <= 1'b0;
      lsu_wdata_q     <= 32'h0;
      lsu_wmask_q     <= 4'h0;
      last_lsu_q      <= 1'b0;
      cnt_q           <= 16'd0;
      mem_reqValid_q  <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_size_q      <= 2'd0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= 32'h0;
      mem_wmask_q     <= 4'h0;
      ifu_respValid_q <= 1'b0;
      ifu_rdata_q     <= 32'h0;
      ifu_err_q       <= 1'b0;
      lsu_respValid_q <= 1'b0;
      lsu_rdata_q     <= 32'h0;
      lsu_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      ifu_pend_q      <= ifu_pend_d;
      ifu_addr_q      <= ifu_addr_d;
      lsu_pend_q      <= lsu_pend_d;
      lsu_addr_q      <= lsu_addr_d;
      lsu_size_q      <= lsu_size_d;
      lsu_wen_q       <= lsu_wen_d;
      lsu_wdata_q     <= lsu_wdata_d;
      lsu_wmask_q     <= lsu_wmask_d;
      last_lsu_q      <= last_lsu_d;
      cnt_q           <= cnt_d;
      mem_reqValid_q  <= mem_reqValid_d;
      mem_addr_q      <= mem_addr_d;
      mem_size_q      <= mem_size_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      ifu_respValid_q <= ifu_respValid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      ifu_err_q       <= ifu_err_d;
      lsu_respValid_q <= lsu_respValid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      lsu_err_q       <= lsu_err_d;
    end
  end

  assign mem_reqValid  = mem_reqValid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_size      = mem_size_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign ifu_respValid = ifu_respValid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign ifu_err       = ifu_err_q;
  assign lsu_respValid = lsu_respValid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign lsu_err       = lsu_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing/arbitration model driving a
// scheduled memory, plus directed reset, spurious-response and timeout scenarios.
module tb_mem_port_arbiter;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hE770_0BAD;

  logic        clock = 1'b0, reset = 1'b1;
  logic        ifu_reqValid = 1'b0, lsu_reqValid = 1'b0, mem_respValid = 1'b0;
  logic [31:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0, mem_rdata = '0;
  logic [1:0]  lsu_size = '0;
  logic        lsu_wen = 1'b0;
  logic [3:0]  lsu_wmask = '0;
  logic        ifu_respValid, ifu_err, lsu_respValid, lsu_err, mem_reqValid, mem_wen;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wmask;

  int ncmp = 0, nerr = 0;
  bit last_lsu = 1'b0;  // model: port granted most recently (0 also means "LSU wins next")

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // One round: each port optionally requests at offset t; delay d (0 = memory never answers).
  // Grant order and every event cycle are derived from the arbitration and latency rules.
  task automatic do_round(input bit hi, input bit hl, input int ti, input int tl,
                          input logic [31:0] ia, input logic [31:0] la, input logic [1:0] ls,
                          input bit lw, input logic [31:0] ld, input logic [3:0] lm,
                          input int di, input int dl, input logic [31:0] ri, input logic [31:0] rl);
    int ord[2], R[2], outc[2], mr[2];
    int n, t, d, eff, last;
    logic [31:0] xa;
    bit exp_mreq, exp_ir, exp_lr, xport, xie, xle;
    logic [31:0] xid, xld;
    n = 0;
    if (hi && hl) begin
      if (ti < tl)      ord[0] = 0;
      else if (tl < ti) ord[0] = 1;
      else              ord[0] = last_lsu ? 0 : 1;
      ord[1] = 1 - ord[0];
      n = 2;
    end else if (hi) begin ord[0] = 0; n = 1; end
    else if (hl)     begin ord[0] = 1; n = 1; end
    for (int k = 0; k < n; k++) begin
      t   = ord[k] ? tl : ti;
      d   = ord[k] ? dl : di;
      eff = (d == 0) ? TO : d;
      R[k] = (k == 0) ? t + 2 : ((outc[k-1] + 2 > t + 2) ? outc[k-1] + 2 : t + 2);
      mr[k]   = (d == 0) ? -1 : R[k] + d;
      outc[k] = R[k] + eff + 1;
    end
    if (n > 0) last_lsu = (ord[n-1] == 1);
    last = (n > 0) ? outc[n-1] + 1 : 3;
    for (int c = 0; c <= last; c++) begin
      @(posedge clock); #1;
      exp_mreq = 0; exp_ir = 0; exp_lr = 0; xport = 0;
      xid = '0; xld = '0; xie = 0; xle = 0;
      for (int k = 0; k < n; k++) begin
        if (c == R[k]) begin exp_mreq = 1; xport = (ord[k] == 1); end
        if (c == outc[k]) begin
          d = ord[k] ? dl : di;
          if (ord[k] == 1) begin exp_lr = 1; xld = (d == 0) ? ERRD : rl; xle = (d == 0); end
          else             begin exp_ir = 1; xid = (d == 0) ? ERRD : ri; xie = (d == 0); end
        end
        if (c > R[k] && c <= outc[k]) begin
          xa = ord[k] ? la : ia;
          ncmp++;
          if (mem_addr !== xa) begin nerr++;
            $display("FAIL mem_addr_hold c=%0d got %h want %h", c, mem_addr, xa); end
        end
      end
      ncmp++;
      if (mem_reqValid !== exp_mreq) begin nerr++;
        $display("FAIL mem_reqValid c=%0d got %b want %b", c, mem_reqValid, exp_mreq); end
      if (exp_mreq) begin
        xa = xport ? la : ia;
        ncmp++;
        if (mem_addr !== xa || mem_wen !== (xport ? lw : 1'b0)) begin nerr++;
          $display("FAIL mem_req_fields c=%0d got addr %h wen %b want addr %h wen %b",
                   c, mem_addr, mem_wen, xa, xport ? lw : 1'b0); end
        if (xport) begin
          ncmp++;
          if (mem_size !== ls || mem_wdata !== ld || mem_wmask !== lm) begin nerr++;
            $display("FAIL mem_lsu_fields c=%0d got %0d/%h/%b want %0d/%h/%b",
                     c, mem_size, mem_wdata, mem_wmask, ls, ld, lm); end
        end
      end
      ncmp++;
      if (ifu_respValid !== exp_ir) begin nerr++;
        $display("FAIL ifu_respValid c=%0d got %b want %b", c, ifu_respValid, exp_ir); end
      if (exp_ir) begin
        ncmp++;
        if (ifu_rdata !== xid || ifu_err !== xie) begin nerr++;
          $display("FAIL ifu_resp c=%0d got %h/%b want %h/%b", c, ifu_rdata, ifu_err, xid, xie); end
      end
      ncmp++;
      if (lsu_respValid !== exp_lr) begin nerr++;
        $display("FAIL lsu_respValid c=%0d got %b want %b", c, lsu_respValid, exp_lr); end
      if (exp_lr) begin
        ncmp++;
        if (lsu_rdata !== xld || lsu_err !== xle) begin nerr++;
          $display("FAIL lsu_resp c=%0d got %h/%b want %h/%b", c, lsu_rdata, lsu_err, xld, xle); end
      end
      // drive this cycle; address buses carry junk when not valid
      ifu_reqValid = hi && (c == ti);
      ifu_addr     = ifu_reqValid ? ia : $urandom;
      lsu_reqValid = hl && (c == tl);
      lsu_addr     = lsu_reqValid ? la : $urandom;
      lsu_size     = lsu_reqValid ? ls : 2'($urandom);
      lsu_wen      = lsu_reqValid ? lw : 1'($urandom);
      lsu_wdata    = lsu_reqValid ? ld : $urandom;
      lsu_wmask    = lsu_reqValid ? lm : 4'($urandom);
      mem_respValid = 1'b0;
      mem_rdata     = $urandom;
      for (int k = 0; k < n; k++)
        if (c == mr[k]) begin mem_respValid = 1'b1; mem_rdata = ord[k] ? rl : ri; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    ncmp++;
    if ({mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask} !== '0) begin nerr++;
      $display("FAIL reset_mem got %b/%h/%0d/%b/%h/%b want all 0",
               mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask); end
    ncmp++;
    if ({ifu_respValid, ifu_rdata, ifu_err} !== '0) begin nerr++;
      $display("FAIL reset_ifu got %b/%h/%b want all 0", ifu_respValid, ifu_rdata, ifu_err); end
    ncmp++;
    if ({lsu_respValid, lsu_rdata, lsu_err} !== '0) begin nerr++;
      $display("FAIL reset_lsu got %b/%h/%b want all 0", lsu_respValid, lsu_rdata, lsu_err); end
    reset = 1'b0;
    last_lsu = 1'b0;
    @(posedge clock); #1;
    ncmp++;
    if ({mem_reqValid, ifu_respValid, lsu_respValid} !== 3'b000) begin nerr++;
      $display("FAIL post_reset_idle got %b want 000", {mem_reqValid, ifu_respValid, lsu_respValid}); end
  endtask

  task automatic test_ifu_alone();
    do_round(1, 0, 0, 0, 32'h8000_0000, '0, 2'd0, 0, '0, 4'h0, 1, 0, 32'h0000_0413, '0);
  endtask

  task automatic test_simultaneous();
    test_reset();
    do_round(1, 1, 0, 0, 32'h8000_0004, 32'h8000_1000, 2'd2, 1, 32'h1234_5678, 4'b1111,
             2, 1, 32'h0000_0013, 32'hCAFE_0001);
  endtask

  task automatic test_fairness();
    for (int r = 0; r < 4; r++)
      do_round(1, 1, 0, 0, 32'h8000_0100 + 32'(r * 4), 32'h9000_0000 + 32'(r * 16), 2'd1, 0,
               '0, 4'b0011, 1 + r, 2, $urandom, $urandom);
  endtask

  task automatic test_timeout();
    do_round(0, 1, 0, 0, '0, 32'h8000_2000, 2'd2, 0, '0, 4'h0, 0, 0, '0, 32'h0);
    do_round(1, 0, 0, 0, 32'h8000_0008, '0, 2'd0, 0, '0, 4'h0, 3, 0, 32'h0000_0517, '0);
  endtask

  task automatic test_spurious();
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      ncmp++;
      if ({mem_reqValid, ifu_respValid, lsu_respValid} !== 3'b000) begin nerr++;
        $display("FAIL spurious c=%0d got %b want 000", c,
                 {mem_reqValid, ifu_respValid, lsu_respValid}); end
      mem_respValid = (c == 1);
      mem_rdata     = 32'hDEAD_BEEF;
    end
    mem_respValid = 1'b0;
    do_round(0, 1, 0, 0, '0, 32'h8000_3000, 2'd0, 0, '0, 4'h0, 0, 1, '0, 32'h0000_00AB);
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c <= 10; c++) begin
      @(posedge clock); #1;
      if (c == 2) begin
        ncmp++;
        if (mem_reqValid !== 1'b1) begin nerr++;
          $display("FAIL midop_req got %b want 1", mem_reqValid); end
      end
      if (c >= 5) begin
        ncmp++;
        if ({mem_reqValid, mem_addr, ifu_respValid, ifu_rdata, lsu_respValid} !== '0) begin nerr++;
          $display("FAIL midop_outputs c=%0d got %b/%h/%b/%h/%b want all 0", c,
                   mem_reqValid, mem_addr, ifu_respValid, ifu_rdata, lsu_respValid); end
      end
      ifu_reqValid  = (c == 0);
      ifu_addr      = 32'h8000_0040;
      reset         = (c == 4);
      mem_respValid = (c == 7);
      mem_rdata     = 32'h5555_AAAA;
    end
    ifu_reqValid = 1'b0; mem_respValid = 1'b0;
    last_lsu = 1'b0;
    do_round(1, 1, 0, 0, 32'h8000_0044, 32'h8000_4000, 2'd2, 1, 32'h0BAD_F00D, 4'b1000,
             1, 1, 32'h0000_0073, 32'h7777_0000);
  endtask

  task automatic test_random();
    bit hi, hl;
    for (int r = 0; r < 30; r++) begin
      hi = 1'($urandom_range(0, 1));
      hl = 1'($urandom_range(0, 1));
      if (!hi && !hl) hi = 1'b1;
      do_round(hi, hl, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom,
               2'($urandom_range(0, 2)), 1'($urandom), $urandom, 4'($urandom),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5), $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_alone();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
